// File: rtl/mem_stage_access.sv
// mem_stage_access
//   MEM-stage consumer of the EX/MEM pipeline register. Runs the load or
//   store held in EX/MEM against a data memory with a req/ack handshake.
//   It steers byte and halfword lanes and sign- or zero-extends loads. It
//   stalls the front of the pipeline until the access completes, then
//   registers the result toward MEM/WB.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   alu_result_in            effective address / ALU result (EX/MEM)
//   r_data2_in               store data (EX/MEM)
//   mux_RegDst_in            destination register (EX/MEM)
//   wb_RegWrite_in           write-back enable (EX/MEM)
//   wb_MemtoReg_in           1 = load (EX/MEM)
//   m_MemWrite_in            1 = store (EX/MEM)
//   opcode_in                MIPS opcode, selects access width and extension
//   stall                    1 = hold PC/IF/ID/EX/EX-MEM latches
//   mem_req/we/addr/wdata/be registered data-memory request
//   mem_rdata, mem_ack       memory read data and one-cycle completion pulse
//   read_data_out            extended load data (to MEM/WB)
//   alu_result_out           ALU result passthrough
//   mux_RegDst_out           destination passthrough
//   wb_RegWrite_out          write-back enable, 0 on bubble or address error
//   wb_MemtoReg_out          MemtoReg passthrough, 0 on bubble
//   addr_err                 misaligned-access pulse, aligned with outputs

module mem_stage_access #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] r_data2_in,
    input  logic [W-1:0] mux_RegDst_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    input  logic         m_MemWrite_in,
    input  logic [5:0]   opcode_in,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [B-1:0] mem_addr,
    output logic [B-1:0] mem_wdata,
    output logic [3:0]   mem_be,
    input  logic [B-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [B-1:0] read_data_out,
    output logic [B-1:0] alu_result_out,
    output logic [W-1:0] mux_RegDst_out,
    output logic         wb_RegWrite_out,
    output logic         wb_MemtoReg_out,
    output logic         addr_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_next;

    logic         is_store, is_load, is_mem;
    logic         is_byte, is_half, sign_ext;
    logic         misaligned;
    logic         start, done;
    logic [B-1:0] st_wdata;
    logic [3:0]   st_be;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [B-1:0] ld_ext;

    // Access decode: a store wins when both MemWrite and MemtoReg are set.
    always_comb begin
        is_store = m_MemWrite_in;
        is_load  = wb_MemtoReg_in & ~m_MemWrite_in;
        is_mem   = is_store | is_load;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        sign_ext = 1'b0;
        case (opcode_in)
            6'h20: begin is_byte = 1'b1; sign_ext = 1'b1; end
            6'h24, 6'h28: is_byte = 1'b1;
            6'h21: begin is_half = 1'b1; sign_ext = 1'b1; end
            6'h25, 6'h29: is_half = 1'b1;
            default: ;
        endcase
        misaligned = 1'b0;
        if (is_mem) begin
            if (is_half)
                misaligned = alu_result_in[0];
            else if (!is_byte)
                misaligned = (alu_result_in[1:0] != 2'b00);
        end
    end

    // Store lane replication and byte enables (little-endian).
    always_comb begin
        st_wdata = r_data2_in;
        st_be    = 4'b1111;
        if (is_byte) begin
            st_wdata = {4{r_data2_in[7:0]}};
            st_be    = 4'b0001 << alu_result_in[1:0];
        end else if (is_half) begin
            st_wdata = {2{r_data2_in[15:0]}};
            st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        end
        if (!is_store)
            st_be = '0;
    end

    // Load lane selection and extension.
    always_comb begin
        ld_byte = mem_rdata[{alu_result_in[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{alu_result_in[1], 4'b0000} +: 16];
        if (is_byte)
            ld_ext = {{(B-8){sign_ext & ld_byte[7]}}, ld_byte};
        else if (is_half)
            ld_ext = {{(B-16){sign_ext & ld_half[15]}}, ld_half};
        else
            ld_ext = mem_rdata;
    end

    // Stall is gated by reset so it drops at once when reset is asserted.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem && !misaligned) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset)
            stall = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {alu_result_in[B-1:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_be    <= st_be;
            end else if (done) begin
                mem_req <= 1'b0;
            end
        end
    end

    // EX/MEM is frozen while stalled, so on the ack edge its inputs still
    // describe the access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_out   <= '0;
            alu_result_out  <= '0;
            mux_RegDst_out  <= '0;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
            addr_err        <= 1'b0;
        end else begin
            alu_result_out <= alu_result_in;
            mux_RegDst_out <= mux_RegDst_in;
            read_data_out  <= '0;
            addr_err       <= 1'b0;
            if (done) begin
                read_data_out   <= is_load ? ld_ext : '0;
                wb_RegWrite_out <= wb_RegWrite_in & ~is_store;
                wb_MemtoReg_out <= wb_MemtoReg_in;
            end else if (state == IDLE && !is_mem) begin
                wb_RegWrite_out <= wb_RegWrite_in;
                wb_MemtoReg_out <= wb_MemtoReg_in;
            end else if (state == IDLE && misaligned) begin
                wb_RegWrite_out <= 1'b0;
                wb_MemtoReg_out <= wb_MemtoReg_in;
                addr_err        <= 1'b1;
            end else begin
                wb_RegWrite_out <= 1'b0;
                wb_MemtoReg_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access
//   Scoreboard bench for mem_stage_access. Each issued instruction pushes
//   its expected MEM/WB result. A monitor pops and compares it on the edge
//   where the instruction leaves the stage. A memory responder acks
//   requests after a programmable delay.

module tb_mem_stage_access;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result_in;
    logic [31:0] r_data2_in;
    logic [4:0]  mux_RegDst_in;
    logic        wb_RegWrite_in;
    logic        wb_MemtoReg_in;
    logic        m_MemWrite_in;
    logic [5:0]  opcode_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  mux_RegDst_out;
    logic        wb_RegWrite_out;
    logic        wb_MemtoReg_out;
    logic        addr_err;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    logic        op_valid;
    logic        will_adv;
    logic        resp_en;
    logic        force_ack;
    int unsigned ack_delay;
    int unsigned wait_cnt;
    logic [31:0] rdata_val;

    mem_stage_access #(.B(32), .W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_result_in   (alu_result_in),
        .r_data2_in      (r_data2_in),
        .mux_RegDst_in   (mux_RegDst_in),
        .wb_RegWrite_in  (wb_RegWrite_in),
        .wb_MemtoReg_in  (wb_MemtoReg_in),
        .m_MemWrite_in   (m_MemWrite_in),
        .opcode_in       (opcode_in),
        .stall           (stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .read_data_out   (read_data_out),
        .alu_result_out  (alu_result_out),
        .mux_RegDst_out  (mux_RegDst_out),
        .wb_RegWrite_out (wb_RegWrite_out),
        .wb_MemtoReg_out (wb_MemtoReg_out),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: acks a pending request ack_delay cycles after it is seen.
    always @(negedge clk) begin
        mem_ack   = force_ack;
        mem_rdata = rdata_val;
        if (resp_en && reset && mem_req) begin
            if (wait_cnt >= ack_delay)
                mem_ack = 1'b1;
            else
                wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    // Output monitor: compares the head of the scoreboard on the advancing edge.
    always @(posedge clk) begin
        if (op_valid && will_adv) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("read_data_out",   read_data_out,           e.rdata);
                check("alu_result_out",  alu_result_out,          e.alu);
                check("mux_RegDst_out",  {27'd0, mux_RegDst_out}, {27'd0, e.rd});
                check("wb_RegWrite_out", {31'd0, wb_RegWrite_out}, {31'd0, e.rw});
                check("wb_MemtoReg_out", {31'd0, wb_MemtoReg_out}, {31'd0, e.mtr});
                check("addr_err",        {31'd0, addr_err},        {31'd0, e.err});
            end
        end
    end

    task automatic issue(input string tag, input logic [5:0] opc, input logic mw, input logic mtr,
                         input logic rw, input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [4:0] rd, input int unsigned dly, input logic [31:0] rdata,
                         input logic [31:0] e_rdata, input logic e_rw, input logic e_mtr,
                         input logic e_err, input int unsigned e_stall, input logic [3:0] e_be,
                         input logic [31:0] e_wdata);
        int unsigned cyc;
        int unsigned nstall;
        exp_t e;
        @(negedge clk);
        opcode_in      = opc;
        m_MemWrite_in  = mw;
        wb_MemtoReg_in = mtr;
        wb_RegWrite_in = rw;
        alu_result_in  = addr;
        r_data2_in     = rd2;
        mux_RegDst_in  = rd;
        ack_delay      = dly;
        rdata_val      = rdata;
        e.rdata = e_rdata;
        e.alu   = addr;
        e.rd    = rd;
        e.rw    = e_rw;
        e.mtr   = e_mtr;
        e.err   = e_err;
        exp_q.push_back(e);
        op_valid = 1'b1;
        cyc    = 0;
        nstall = 0;
        forever begin
            #1;
            if (cyc > 0) begin
                check({tag, "_req"},  {31'd0, mem_req}, 32'd1);
                check({tag, "_we"},   {31'd0, mem_we},  {31'd0, mw});
                check({tag, "_addr"}, mem_addr,         {addr[31:2], 2'b00});
                check({tag, "_be"},   {28'd0, mem_be},  {28'd0, e_be});
                if (mw)
                    check({tag, "_wdata"}, mem_wdata, e_wdata);
                check({tag, "_bubble_rw"},  {31'd0, wb_RegWrite_out}, 32'd0);
                check({tag, "_bubble_mtr"}, {31'd0, wb_MemtoReg_out}, 32'd0);
            end
            if (stall)
                nstall++;
            will_adv = ~stall;
            if (!stall)
                break;
            if (cyc >= 100) begin
                check({tag, "_timeout"}, 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #2;
        op_valid = 1'b0;
        will_adv = 1'b0;
        check({tag, "_stall_cycles"}, nstall, e_stall);
        check({tag, "_req_after"}, {31'd0, mem_req}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, mem_req}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall},   32'd0);
        check({tag, "_mem"},   {31'd0, (|{mem_we, mem_addr, mem_wdata, mem_be})}, 32'd0);
        check({tag, "_rdata"}, read_data_out,  32'd0);
        check({tag, "_alu"},   alu_result_out, 32'd0);
        check({tag, "_ctl"},   {26'd0, mux_RegDst_out, wb_RegWrite_out}, 32'd0);
        check({tag, "_mtr_err"}, {30'd0, wb_MemtoReg_out, addr_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        alu_result_in = '0; r_data2_in = '0; mux_RegDst_in = '0;
        wb_RegWrite_in = 1'b0; wb_MemtoReg_in = 1'b0; m_MemWrite_in = 1'b0;
        opcode_in = '0;
        resp_en = 1'b1; force_ack = 1'b0; ack_delay = 0; rdata_val = '0;
        wait_cnt = 0; op_valid = 1'b0; will_adv = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        //    tag       opc    mw mtr rw addr          rd2           rd  dly rdata          e_rdata        rw mtr err stl be       wdata
        issue("nop",    6'h00, 0, 0, 1, 32'h0000_1234, 32'h0,        7,  0, 32'h0,         32'h0,         1, 0, 0, 0, 4'h0,    32'h0);
        issue("sw",     6'h2B, 1, 0, 0, 32'h0000_0100, 32'hDEADBEEF, 0,  3, 32'h0,         32'h0,         0, 0, 0, 4, 4'hF,    32'hDEADBEEF);
        issue("lb",     6'h20, 0, 1, 1, 32'h0000_0103, 32'h0,        9,  0, 32'h80FF_0000, 32'hFFFF_FF80, 1, 1, 0, 1, 4'h0,    32'h0);
        issue("lbu",    6'h24, 0, 1, 1, 32'h0000_0103, 32'h0,        9,  0, 32'h80FF_0000, 32'h0000_0080, 1, 1, 0, 1, 4'h0,    32'h0);
        issue("sh",     6'h29, 1, 0, 0, 32'h0000_0102, 32'h0000_ABCD, 0, 1, 32'h0,         32'h0,         0, 0, 0, 2, 4'b1100, 32'hABCD_ABCD);
        issue("lw_mis", 6'h23, 0, 1, 1, 32'h0000_0102, 32'h0,        4,  0, 32'h0,         32'h0,         0, 1, 1, 0, 4'h0,    32'h0);
        issue("lh",     6'h21, 0, 1, 1, 32'h0000_0102, 32'h0,        2,  1, 32'h8001_1234, 32'hFFFF_8001, 1, 1, 0, 2, 4'h0,    32'h0);
        issue("lhu",    6'h25, 0, 1, 1, 32'h0000_0100, 32'h0,        2,  0, 32'h8001_F234, 32'h0000_F234, 1, 1, 0, 1, 4'h0,    32'h0);
        issue("sb",     6'h28, 1, 0, 0, 32'h0000_0101, 32'h1234_56A5, 0, 0, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0010, 32'hA5A5_A5A5);
        issue("sw_mis", 6'h2B, 1, 0, 0, 32'h0000_0101, 32'h1111_1111, 0, 0, 32'h0,         32'h0,         0, 0, 1, 0, 4'h0,    32'h0);
        issue("lh_mis", 6'h21, 0, 1, 1, 32'h0000_0101, 32'h0,        8,  0, 32'h0,         32'h0,         0, 1, 1, 0, 4'h0,    32'h0);
        issue("lw_a",   6'h23, 0, 1, 1, 32'h0000_0200, 32'h0,        3,  0, 32'h1111_2222, 32'h1111_2222, 1, 1, 0, 1, 4'h0,    32'h0);
        issue("lw_b",   6'h23, 0, 1, 1, 32'h0000_0204, 32'h0,        5,  0, 32'h3333_4444, 32'h3333_4444, 1, 1, 0, 1, 4'h0,    32'h0);
        issue("nop2",   6'h00, 0, 0, 0, 32'h0000_0055, 32'h0,        1,  0, 32'h0,         32'h0,         0, 0, 0, 0, 4'h0,    32'h0);

        // Reset in the middle of a pending load.
        @(negedge clk);
        resp_en = 1'b0;
        opcode_in = 6'h23; m_MemWrite_in = 1'b0; wb_MemtoReg_in = 1'b1; wb_RegWrite_in = 1'b1;
        alu_result_in = 32'h0000_0300; mux_RegDst_in = 5'd6;
        @(posedge clk);
        #1;
        check("rst_pre_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #1;
        check("rst_pre_stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #2;
        force_ack = 1'b1;
        rdata_val = 32'hCAFE_F00D;
        opcode_in = 6'h00; m_MemWrite_in = 1'b0; wb_MemtoReg_in = 1'b0; wb_RegWrite_in = 1'b1;
        alu_result_in = 32'h0000_1234; mux_RegDst_in = 5'd7;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("late_ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_alu", alu_result_out, 32'h0000_1234);
        check("post_rst_rd",  {27'd0, mux_RegDst_out}, 32'd7);
        check("post_rst_rw",  {31'd0, wb_RegWrite_out}, 32'd1);
        check("post_rst_mtr_err", {30'd0, wb_MemtoReg_out, addr_err}, 32'd0);
        resp_en = 1'b1;
        issue("nop3",   6'h00, 0, 0, 1, 32'h0000_1234, 32'h0,        7,  0, 32'h0,         32'h0,         1, 0, 0, 0, 4'h0,    32'h0);

        check("sb_leftover", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
